pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and memory-wait controller for a 5-stage RISC-V pipeline.
// Drives stage write enables, bubbles, a timeout halt and perf counters.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             ifid_uses_rs2,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rd,
  input  logic             exmem_branch_taken,
  input  logic             exmem_memread,
  input  logic             exmem_memwrite,
  input  logic             dmem_ack,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             dmem_req,
  output logic [1:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [1:0] RUN      = 2'b00;
  localparam logic [1:0] MEM_WAIT = 2'b01;
  localparam logic [1:0] HALT     = 2'b10;

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_ONE = WC_W'(1);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(MEM_TIMEOUT);

  logic [1:0]      state_q, state_d;
  logic [WC_W-1:0] wait_q, wait_d;

  logic mem_acc, load_use;
  logic in_halt, in_wait, active;
  logic hz_mem, hz_br, hz_lu;
  logic br_flush;

  assign mem_acc  = exmem_memread | exmem_memwrite;
  assign load_use = idex_memread && (idex_rd != 5'd0) &&
                    ((idex_rd == ifid_rs1) ||
                     (ifid_uses_rs2 && (idex_rd == ifid_rs2)));

  // Reset masks registered state so outputs show RUN defaults.
  assign in_halt = !reset && (state_q == HALT);
  assign in_wait = !reset && (state_q == MEM_WAIT);
  assign active  = !reset && !in_halt;

  assign hz_mem = active && mem_acc && !dmem_ack;
  assign hz_br  = active && !hz_mem && exmem_branch_taken;
  assign hz_lu  = active && !hz_mem && !exmem_branch_taken && load_use;

  assign dmem_req = mem_acc && !in_halt;
  assign state    = reset ? RUN : state_q;
  assign halted   = in_halt;

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    exmem_write = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    br_flush    = 1'b0;
    state_d     = in_halt ? HALT : RUN;
    wait_d      = in_halt ? wait_q : '0;
    unique case (1'b1)
      in_halt: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_write  = 1'b0;
        exmem_write = 1'b0;
        memwb_flush = 1'b1;
      end
      hz_mem: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_write  = 1'b0;
        exmem_write = 1'b0;
        memwb_flush = 1'b1;
        state_d     = MEM_WAIT;
        if (!in_wait) begin
          wait_d = WC_ONE;
        end else if (wait_q == WC_MAX) begin
          state_d = HALT;
          wait_d  = wait_q;
        end else begin
          wait_d = wait_q + WC_ONE;
        end
      end
      hz_br: begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        br_flush    = 1'b1;
      end
      hz_lu: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      wait_q      <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (!in_halt && !pc_write && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
      if (br_flush && (flush_count != '1))
        flush_count <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized bench for pipeline_hazard_ctrl against a rule-level model.
// Small counters are used so saturation is reached.
module tb_pipeline_hazard_ctrl;

  localparam int TO   = 16;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] ifid_rs1, ifid_rs2, idex_rd;
  logic ifid_uses_rs2, idex_memread, exmem_branch_taken;
  logic exmem_memread, exmem_memwrite, dmem_ack;
  logic pc_write, ifid_write, idex_write, exmem_write;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic dmem_req, halted;
  logic [1:0] state;
  logic [CW-1:0] stall_count, flush_count;

  int n_chk = 0;
  int n_err = 0;

  // model: mode 0 run, 1 waiting, 2 halted
  int mode = 0;
  int waits = 0;
  int sc = 0;
  int fc = 0;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_uses_rs2(ifid_uses_rs2),
    .idex_memread(idex_memread), .idex_rd(idex_rd),
    .exmem_branch_taken(exmem_branch_taken),
    .exmem_memread(exmem_memread),
    .exmem_memwrite(exmem_memwrite),
    .dmem_ack(dmem_ack),
    .pc_write(pc_write), .ifid_write(ifid_write),
    .idex_write(idex_write), .exmem_write(exmem_write),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
    .dmem_req(dmem_req), .state(state), .halted(halted),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input int rs1, input int rs2,
                       input bit u2, input bit imr, input int ird,
                       input bit br, input bit emr, input bit emw,
                       input bit ack);
    int acc, busy, lu, wr, bf, lus;
    int e_if, e_id, e_ex, e_wb, e_pc, e_ifw;
    @(negedge clk);
    reset = r;
    ifid_rs1 = 5'(rs1);
    ifid_rs2 = 5'(rs2);
    ifid_uses_rs2 = u2;
    idex_memread = imr;
    idex_rd = 5'(ird);
    exmem_branch_taken = br;
    exmem_memread = emr;
    exmem_memwrite = emw;
    dmem_ack = ack;
    #1;
    acc  = (emr || emw) ? 1 : 0;
    busy = (acc == 1 && !ack) ? 1 : 0;
    lu   = (imr && ird != 0 &&
            (ird == rs1 || (u2 && ird == rs2))) ? 1 : 0;
    wr = 1; e_pc = 1; e_ifw = 1;
    e_if = 0; e_id = 0; e_ex = 0; e_wb = 0;
    bf = 0; lus = 0;
    if (!r && mode == 2) begin
      wr = 0; e_pc = 0; e_ifw = 0; e_wb = 1;
    end else if (!r && busy == 1) begin
      wr = 0; e_pc = 0; e_ifw = 0; e_wb = 1;
    end else if (!r && br) begin
      e_if = 1; e_id = 1; e_ex = 1; bf = 1;
    end else if (!r && lu == 1) begin
      e_pc = 0; e_ifw = 0; e_id = 1; lus = 1;
    end
    chk("pc_write", int'(pc_write), e_pc);
    chk("ifid_write", int'(ifid_write), e_ifw);
    chk("idex_write", int'(idex_write), wr);
    chk("exmem_write", int'(exmem_write), wr);
    chk("ifid_flush", int'(ifid_flush), e_if);
    chk("idex_flush", int'(idex_flush), e_id);
    chk("exmem_flush", int'(exmem_flush), e_ex);
    chk("memwb_flush", int'(memwb_flush), e_wb);
    chk("dmem_req", int'(dmem_req), (!r && mode == 2) ? 0 : acc);
    chk("state", int'(state), r ? 0 : mode);
    chk("halted", int'(halted), (!r && mode == 2) ? 1 : 0);
    chk("stall_count", int'(stall_count), sc);
    chk("flush_count", int'(flush_count), fc);
    if (r) begin
      mode = 0; waits = 0; sc = 0; fc = 0;
    end else if (mode != 2) begin
      if (e_pc == 0 && sc < CMAX) sc++;
      if (bf == 1 && fc < CMAX) fc++;
      if (busy == 1) begin
        if (mode == 1) begin
          waits++;
          if (waits == TO) mode = 2;
        end else begin
          mode = 1;
          waits = 0;
        end
      end else begin
        mode = 0;
        waits = 0;
      end
    end
  endtask

  task automatic idle(input bit r);
    drive(r, 1, 2, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);
    // load-use on rs1
    drive(0, 5, 0, 0, 1, 5, 0, 0, 0, 0);
    idle(1'b0);
    chk("lu_stall_cnt", int'(stall_count), 1);
    // x0 destination and unused rs2
    drive(0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    drive(0, 1, 5, 0, 1, 5, 0, 0, 0, 0);
    drive(0, 1, 5, 1, 1, 5, 0, 0, 0, 0);
    // branch beats load-use
    drive(0, 5, 0, 0, 1, 5, 1, 0, 0, 0);
    idle(1'b0);
    chk("br_flush_cnt", int'(flush_count), 1);
    chk("br_stall_cnt", int'(stall_count), 2);
    // three wait cycles then ack
    idle(1'b1);
    repeat (3) drive(0, 1, 2, 1, 0, 0, 0, 1, 0, 0);
    drive(0, 1, 2, 1, 0, 0, 0, 1, 0, 1);
    idle(1'b0);
    chk("mw_stall_cnt", int'(stall_count), 3);
    // timeout into HALT, then reset recovers
    idle(1'b1);
    repeat (20) drive(0, 1, 2, 1, 0, 0, 0, 0, 1, 0);
    chk("to_halted", int'(halted), 1);
    chk("to_req", int'(dmem_req), 0);
    idle(1'b1);
    idle(1'b0);
    chk("rst_state", int'(state), 0);
    chk("rst_stall", int'(stall_count), 0);
    // branch held through a memory wait
    repeat (2) drive(0, 1, 2, 1, 0, 0, 1, 1, 0, 0);
    drive(0, 1, 2, 1, 0, 0, 1, 1, 0, 1);
    idle(1'b0);
    chk("mwbr_flush_cnt", int'(flush_count), 1);
    for (int i = 0; i < 3000; i++) begin
      bit stuck;
      stuck = ($urandom_range(0, 9) == 0);
      drive($urandom_range(0, 79) == 0,
            $urandom_range(0, 3), $urandom_range(0, 3),
            1'($urandom), $urandom_range(0, 2) == 0,
            $urandom_range(0, 3), $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
            stuck ? 1'b0 : ($urandom_range(0, 2) == 0));
      if (stuck)
        repeat (18) drive(0, 1, 2, 1, 0, 0, 0, 1, 0, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
